// File: rtl/fetch_seq_if.sv
// Bus between the decoder/test side and the fetch sequencer (PC, retire and stall signals).
// The FETCH_PERF_CNT_EN macro adds the cycle_count/instr_count performance counters.
interface fetch_seq_if #(
    parameter int PC_WIDTH = 10
);
    logic                start;
    logic                halt;
    logic                mem_access;
    logic                jump;
    logic [PC_WIDTH-1:0] jump_target;
    logic                branch_taken;
    logic [7:0]          branch_offset;
    logic [PC_WIDTH-1:0] pc;
    logic                commit;
    logic                stall;
    logic                done;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]         cycle_count;
    logic [15:0]         instr_count;

    modport master (
        output start, halt, mem_access, jump, jump_target, branch_taken, branch_offset,
        input  pc, commit, stall, done, cycle_count, instr_count
    );

    modport slave (
        input  start, halt, mem_access, jump, jump_target, branch_taken, branch_offset,
        output pc, commit, stall, done, cycle_count, instr_count
    );
`else
    modport master (
        output start, halt, mem_access, jump, jump_target, branch_taken, branch_offset,
        input  pc, commit, stall, done
    );

    modport slave (
        input  start, halt, mem_access, jump, jump_target, branch_taken, branch_offset,
        output pc, commit, stall, done
    );
`endif
endinterface

// File: rtl/fetch_seq_ctrl.sv
// PC sequencer and retire controller: sequential/branch/JR/HALT flow plus fixed-latency memory stalls.
// The FETCH_PERF_CNT_EN macro adds saturating cycle and instruction counters.
module fetch_seq_ctrl #(
    parameter int                  PC_WIDTH   = 10,
    parameter logic [PC_WIDTH-1:0] START_ADDR = '0,
    parameter int                  MEM_LAT    = 2
) (
    input  logic       clk,
    input  logic       reset,
    fetch_seq_if.slave bus
);
    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        MEM_WAIT,
        HALTED
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] pc_plus_one;
    logic [PC_WIDTH-1:0] offset_ext;
    logic [CNT_W-1:0]    wait_cnt;
    logic [CNT_W-1:0]    next_wait_cnt;
    logic                commit_raw;
    logic                stall_c;
    logic                done_c;

    assign pc_plus_one = pc_q + PC_WIDTH'(1);
    assign offset_ext  = PC_WIDTH'($signed(bus.branch_offset));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc_q     <= START_ADDR;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            pc_q     <= next_pc;
            wait_cnt <= next_wait_cnt;
        end
    end

    always_comb begin
        next_state    = state;
        next_pc       = pc_q;
        next_wait_cnt = wait_cnt;
        commit_raw    = 1'b0;
        stall_c       = 1'b0;
        done_c        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_pc    = START_ADDR;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (bus.halt) begin
                    commit_raw = 1'b1;
                    next_state = HALTED;
                end else if (bus.mem_access) begin
                    if (MEM_LAT == 1) begin
                        commit_raw = 1'b1;
                        next_pc    = pc_plus_one;
                    end else begin
                        stall_c       = 1'b1;
                        next_wait_cnt = WAIT_INIT;
                        next_state    = MEM_WAIT;
                    end
                end else if (bus.jump) begin
                    commit_raw = 1'b1;
                    next_pc    = bus.jump_target;
                end else if (bus.branch_taken) begin
                    commit_raw = 1'b1;
                    next_pc    = pc_q + offset_ext;
                end else begin
                    commit_raw = 1'b1;
                    next_pc    = pc_plus_one;
                end
            end
            MEM_WAIT: begin
                // The load/store retires only in the final cycle of its latency window.
                if (wait_cnt != '0) begin
                    stall_c       = 1'b1;
                    next_wait_cnt = wait_cnt - CNT_W'(1);
                end else begin
                    commit_raw = 1'b1;
                    next_pc    = pc_plus_one;
                    next_state = RUN;
                end
            end
            HALTED: begin
                done_c = 1'b1;
                if (bus.start) begin
                    next_pc    = START_ADDR;
                    next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A reset cycle must never let a register-file or memory write through.
    assign bus.commit = commit_raw & ~reset;
    assign bus.stall  = stall_c;
    assign bus.done   = done_c;
    assign bus.pc     = pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cycle_q;
    logic [15:0] instr_q;
    logic        perf_clear;

    assign perf_clear = bus.start && (state == IDLE || state == HALTED);

    always_ff @(posedge clk) begin
        if (reset || perf_clear) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if ((state == RUN || state == MEM_WAIT) && cycle_q != 16'hFFFF) begin
                cycle_q <= cycle_q + 16'd1;
            end
            if (bus.commit && instr_q != 16'hFFFF) begin
                instr_q <= instr_q + 16'd1;
            end
        end
    end

    assign bus.cycle_count = cycle_q;
    assign bus.instr_count = instr_q;
`endif
endmodule
